// File: rtl/alu_bist.sv
// alu_bist: sequential built-in self-test driver for the datapath ALU.
// Walks the ops AND, OR, ADD, SUB, SLT in that order, applying NUM_VECTORS
// LFSR-generated operand pairs to each. Every ALU response is checked against
// an internal golden model. Mismatches are counted, and the first one is
// captured.
//
// Optional feature macro: ALU_BIST_STOP_ON_FAIL_EN. When it is defined, the
// first mismatch ends the run immediately.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             begin a run (honoured only in IDLE or DONE)
//   alu_a/alu_b/alu_op  stimulus driven onto the ALU (registered)
//   alu_res/alu_zero  ALU response (combinational from the stimulus)
//   busy, done, pass  run status; pass is valid while done is high
//   err_count         saturating count of mismatching vectors
//   fail_valid, fail_op/fail_a/fail_b  stimulus of the first mismatch
module alu_bist #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'hACE10001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_op,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int unsigned LfsrW   = 32;
  localparam int unsigned CntW    = 16;
  localparam int unsigned OpIdxW  = 3;
  localparam int unsigned NumOps  = 5;

  // Galois taps for x^32+x^22+x^2+x+1 (right-shifting form)
  localparam logic [LfsrW-1:0] LfsrTaps = 32'h8020_0003;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

`ifdef ALU_BIST_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic [LfsrW-1:0]  lfsr_q, lfsr_d;
  logic [OpIdxW-1:0] op_idx_q, op_idx_d;
  logic [CntW-1:0]   vec_idx_q, vec_idx_d;
  logic [WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CntW-1:0]   err_count_q, err_count_d;
  logic              fail_valid_q, fail_valid_d;
  logic [2:0]        fail_op_q, fail_op_d;
  logic [WIDTH-1:0]  fail_a_q, fail_a_d;
  logic [WIDTH-1:0]  fail_b_q, fail_b_d;

  logic [WIDTH-1:0]  gold_res_c;
  logic              gold_zero_c;
  logic              mismatch_c;
  logic [LfsrW-1:0]  lfsr_step_c;
  logic              last_vec_c;
  logic              last_op_c;

  // Map the op index onto the ALU op encoding, in test order
  function automatic logic [2:0] op_code(input logic [OpIdxW-1:0] idx);
    logic [2:0] code;
    code = OP_AND;
    case (idx)
      3'd0:    code = OP_AND;
      3'd1:    code = OP_OR;
      3'd2:    code = OP_ADD;
      3'd3:    code = OP_SUB;
      3'd4:    code = OP_SLT;
      default: code = OP_AND;
    endcase
    return code;
  endfunction

  // Golden ALU model evaluated on the stimulus currently driven
  always_comb begin
    gold_res_c = '0;
    case (alu_op_q)
      OP_AND:  gold_res_c = alu_a_q & alu_b_q;
      OP_OR:   gold_res_c = alu_a_q | alu_b_q;
      OP_ADD:  gold_res_c = alu_a_q + alu_b_q;
      OP_SUB:  gold_res_c = alu_a_q - alu_b_q;
      OP_SLT:  gold_res_c = WIDTH'($signed(alu_a_q) < $signed(alu_b_q));
      default: gold_res_c = '0;
    endcase
    gold_zero_c = (gold_res_c == '0);
    mismatch_c  = (alu_res != gold_res_c) || (alu_zero != gold_zero_c);
  end

  // One Galois LFSR step and the end-of-stream conditions
  always_comb begin
    lfsr_step_c = {1'b0, lfsr_q[LfsrW-1:1]} ^ (lfsr_q[0] ? LfsrTaps : '0);
    last_vec_c  = (vec_idx_q == CntW'(NUM_VECTORS - 1));
    last_op_c   = (op_idx_q == OpIdxW'(NumOps - 1));
  end

  // Next-state and datapath logic
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    op_idx_d     = op_idx_q;
    vec_idx_d    = vec_idx_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    fail_valid_d = fail_valid_q;
    fail_op_d    = fail_op_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_DRIVE;
          lfsr_d       = SEED;
          op_idx_d     = '0;
          vec_idx_d    = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_count_d  = '0;
          fail_valid_d = 1'b0;
          fail_op_d    = '0;
          fail_a_d     = '0;
          fail_b_d     = '0;
        end
      end

      S_DRIVE: begin
        // Vector 0 of each op repeats operand A to hit the A==B corner
        alu_a_d  = lfsr_q[WIDTH-1:0];
        alu_b_d  = (vec_idx_q == '0) ? lfsr_q[WIDTH-1:0] : lfsr_q[LfsrW-1 -: WIDTH];
        alu_op_d = op_code(op_idx_q);
        state_d  = S_CHECK;
      end

      S_CHECK: begin
        if (mismatch_c) begin
          if (err_count_q != '1) begin
            err_count_d = err_count_q + CntW'(1);
          end
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_op_d    = alu_op_q;
            fail_a_d     = alu_a_q;
            fail_b_d     = alu_b_q;
          end
        end
        lfsr_d = lfsr_step_c;
        if (last_vec_c) begin
          vec_idx_d = '0;
          op_idx_d  = op_idx_q + OpIdxW'(1);
        end else begin
          vec_idx_d = vec_idx_q + CntW'(1);
        end
        if ((last_vec_c && last_op_c) || (StopOnFail && mismatch_c)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_q == '0) && !mismatch_c;
        end else begin
          state_d = S_DRIVE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED;
      op_idx_q     <= '0;
      vec_idx_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      fail_op_q    <= '0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      op_idx_q     <= op_idx_d;
      vec_idx_q    <= vec_idx_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      fail_op_q    <= fail_op_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_op    = fail_op_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Sequential built-in self-test driver for the datapath ALU. It drives the ALU operand and op inputs and consumes its result and zero outputs.
- For each supported op it generates a pseudo-random vector stream, compares the ALU response against an internal golden model, and reports pass/fail with first-failure capture.
- Sits beside the ALU in the single-cycle core. It is muxed onto the ALU inputs during test mode only.

Parameters:
- WIDTH, 4, ALU data width (1..32).
- NUM_VECTORS, 16, vectors applied per op (2..65535).
- SEED, 32'hACE10001, LFSR seed loaded on every start (must be nonzero).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a test run; sampled only in IDLE or DONE.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_op  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- alu_res  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_zero  input  1  ALU zero flag.
- busy  output  1  high while the run is in progress.
- done  output  1  high (level) once the run has completed, until the next start.
- pass  output  1  valid when done; 1 if err_count==0.
- err_count  output  16  mismatching vectors; saturates at 16'hFFFF.
- fail_valid  output  1  a failure has been captured.
- fail_op, fail_a, fail_b  output  3/WIDTH/WIDTH  stimulus of the first mismatch.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; LFSR=SEED; all outputs 0, including alu_op=000. Reset mid-run aborts immediately; no partial results are retained.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE / DONE:
  - start=1 moves to DRIVE.
  - On that same edge: clear err_count, fail_*, pass and done; set op index=0, vector index=0, LFSR=SEED.
- DRIVE (1 cycle):
  - Register alu_a/alu_b/alu_op.
  - Vector 0 of each op: alu_a=alu_b=LFSR[WIDTH-1:0] (forces an equal-operand corner).
  - Other vectors: alu_a=LFSR[WIDTH-1:0], alu_b=LFSR[31:32-WIDTH].
  - Next state CHECK.
- CHECK (1 cycle): compare alu_res/alu_zero against golden.
  - On mismatch: err_count+1 (saturating). If fail_valid=0, capture fail_op/a/b and set fail_valid.
  - Then advance the LFSR one step: Galois, 32-bit, x^32+x^22+x^2+x+1.
  - Increment the vector index. On wrap at NUM_VECTORS, go to the next op in order 000,001,010,110,111.
  - After the last vector of op 111, go to DONE. Otherwise go to DRIVE.
- The LFSR is not reseeded between ops, only at start.
- Golden model:
  - AND/OR bitwise.
  - ADD/SUB modulo 2^WIDTH; carry and overflow ignored.
  - SLT = 1 (zero-extended) if $signed(A)<$signed(B), else 0.
  - zero = (golden res == 0).
  - Mismatch if either res or zero differs.
- Timing:
  - busy=1 from the cycle after start through the final CHECK.
  - Run length is exactly 10*NUM_VECTORS busy cycles.
  - done and pass assert together on entry to DONE.
- start while busy is ignored.
- alu_a/b/op hold their last values in DONE.

Optional Feature:
- Macro ALU_BIST_STOP_ON_FAIL_EN.
- When defined: the first mismatch sends CHECK→DONE directly, so err_count=1, pass=0 and fail_* hold that vector.
- When undefined: the full run always completes and all mismatches are counted.

Test Plan:
- Correct ALU model, defaults, start pulse:
  - busy for exactly 160 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
  - Vector 0 of SUB shows alu_zero=1.
- Faulty ALU forcing alu_res=4'b1111 only when op=111:
  - err_count=16, pass=0, fail_op=111, fail_a==fail_b (SLT vector 0).
- Same fault with ALU_BIST_STOP_ON_FAIL_EN:
  - done 1 cycle after the first SLT CHECK, err_count=1, fail_op=111.
- Assert rst=0 at cycle 50 of a run:
  - All outputs 0 immediately.
  - After release, a new start gives a run identical to the fresh-reset run (same alu_a/alu_b sequence).
- start held high across the whole run:
  - No restart while busy.
  - Run ends at cycle 160.
  - Start seen in DONE begins a new run with err_count cleared.
- ALU with alu_zero stuck at 0:
  - SUB vector 0 is counted.
  - err_count ≥ 1, fail_op is the first op with a zero result.
